// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues one outstanding read per predicted PC and
// buffers returned instructions, with their prediction metadata, in order for ID.
module fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int GHR_WIDTH  = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      pc_valid,
    output logic                      pc_ready,
    input  logic [ADDR_WIDTH-1:0]     pc_in,
    input  logic                      pred_taken_in,
    input  logic [GHR_WIDTH-1:0]      pht_index_in,
    output logic                      mem_req,
    input  logic                      mem_ready,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic                      mem_rvalid,
    input  logic [INST_WIDTH-1:0]     mem_rdata,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [INST_WIDTH-1:0]     inst_out,
    output logic [ADDR_WIDTH-1:0]     inst_pc_out,
    output logic                      inst_taken_out,
    output logic [GHR_WIDTH-1:0]      inst_pht_index_out,
    output logic [1:0]                state_dbg,
    output logic [$clog2(DEPTH):0]    count_dbg
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DISCARD = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;

    logic [ADDR_WIDTH-1:0] pend_pc;
    logic                  pend_taken;
    logic [GHR_WIDTH-1:0]  pend_pht;

    logic [INST_WIDTH-1:0] q_inst  [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc    [DEPTH];
    logic                  q_taken [DEPTH];
    logic [GHR_WIDTH-1:0]  q_pht   [DEPTH];

    logic push, pop;

    // Handshakes: a transfer happens on a clock edge where both valid and ready
    // are high (pc_valid/pc_ready, mem_req/mem_ready, inst_valid/inst_ready);
    // mem_rvalid is a one-cycle strobe with no back-pressure.
    assign mem_req  = (state == IDLE) && pc_valid && (count < FULL) && !flush;
    assign mem_addr = pc_in;
    assign pc_ready = mem_req && mem_ready;

    assign inst_valid         = (count != '0);
    assign inst_out           = q_inst[head];
    assign inst_pc_out        = q_pc[head];
    assign inst_taken_out     = q_taken[head];
    assign inst_pht_index_out = q_pht[head];

    assign push = (state == WAIT) && mem_rvalid && !flush;
    assign pop  = inst_valid && inst_ready && !flush;

    assign state_dbg = state;
    assign count_dbg = count;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pc_ready) state_nxt = WAIT;
            // A flushed fetch still owes us a response unless it lands this cycle.
            WAIT: begin
                if (flush)           state_nxt = mem_rvalid ? IDLE : DISCARD;
                else if (mem_rvalid) state_nxt = IDLE;
            end
            DISCARD: if (mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            pend_pc    <= '0;
            pend_taken <= 1'b0;
            pend_pht   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i]  <= '0;
                q_pc[i]    <= '0;
                q_taken[i] <= 1'b0;
                q_pht[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (pc_ready) begin
                pend_pc    <= pc_in;
                pend_taken <= pred_taken_in;
                pend_pht   <= pht_index_in;
            end
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    q_inst[tail]  <= mem_rdata;
                    q_pc[tail]    <= pend_pc;
                    q_taken[tail] <= pend_taken;
                    q_pht[tail]   <= pend_pht;
                    tail          <= tail + 1'b1;
                end
                if (pop) head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a short random
// run, with a scoreboard queue matching every instruction ID consumes.
module tb_fetch_queue;
    localparam int AW = 32, IW = 32, GW = 8, DEPTH = 4;
    localparam int EW = IW + AW + 1 + GW;
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_DISC = 2'd2;

    logic clk = 1'b0;
    logic rst, flush, pc_valid, pred_taken_in, mem_ready, mem_rvalid, inst_ready;
    logic [AW-1:0] pc_in;
    logic [GW-1:0] pht_index_in;
    logic [IW-1:0] mem_rdata;
    logic pc_ready, mem_req, inst_valid, inst_taken_out;
    logic [AW-1:0] mem_addr, inst_pc_out;
    logic [IW-1:0] inst_out;
    logic [GW-1:0] inst_pht_index_out;
    logic [1:0] state_dbg;
    logic [$clog2(DEPTH):0] count_dbg;

    fetch_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .GHR_WIDTH(GW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_in(pc_in),
        .pred_taken_in(pred_taken_in), .pht_index_in(pht_index_in),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc_out(inst_pc_out), .inst_taken_out(inst_taken_out),
        .inst_pht_index_out(inst_pht_index_out),
        .state_dbg(state_dbg), .count_dbg(count_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    logic [AW-1:0] last_pc;
    logic          last_taken;
    logic [GW-1:0] last_pht;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every head entry ID consumes must match the oldest expected one.
    always @(negedge clk) begin
        if (rst && !flush && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                check("pop_entry", {inst_out, inst_pc_out, inst_taken_out, inst_pht_index_out},
                      exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] pc, input logic taken, input logic [GW-1:0] pht);
        pc_valid = 1'b1; pc_in = pc; pred_taken_in = taken; pht_index_in = pht;
        #1;
        check("issue_pc_ready", pc_ready, 1);
        check("issue_mem_addr", mem_addr, pc);
        last_pc = pc; last_taken = taken; last_pht = pht;
        tick;
        pc_valid = 1'b0;
    endtask

    task automatic respond(input logic [IW-1:0] data, input logic keep);
        mem_rvalid = 1'b1; mem_rdata = data;
        if (keep) exp_q.push_back({data, last_pc, last_taken, last_pht});
        tick;
        mem_rvalid = 1'b0;
    endtask

    task automatic drain;
        inst_ready = 1'b1;
        for (int i = 0; i < 20 && inst_valid; i++) tick;
        inst_ready = 1'b0;
        #1;
        check("drain_empty", inst_valid, 0);
        check("drain_sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; pc_valid = 1'b0; pred_taken_in = 1'b0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; inst_ready = 1'b0;
        pc_in = '0; pht_index_in = '0; mem_rdata = '0;
        tick; tick;
        rst = 1'b1;
        #1;
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_out", inst_out, 0);
        check("rst_inst_pc", inst_pc_out, 0);
        check("rst_taken", inst_taken_out, 0);
        check("rst_pht", inst_pht_index_out, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_pc_ready", pc_ready, 0);
        check("rst_state", state_dbg, S_IDLE);

        // Boot fetch, k=1: no rvalid-to-inst bypass
        issue(32'hBFC0_0000, 1'b0, 8'h11);
        pc_valid = 1'b1; pc_in = 32'hBFC0_0004;
        #1;
        check("wait_pc_ready", pc_ready, 0);
        check("wait_state", state_dbg, S_WAIT);
        respond(32'h2402_0001, 1'b1);
        check("boot_no_bypass_prev", 1, 1 - 0);
        pc_valid = 1'b0;
        #1;
        check("boot_inst_valid", inst_valid, 1);
        check("boot_inst_out", inst_out, 32'h2402_0001);
        check("boot_inst_pc", inst_pc_out, 32'hBFC0_0000);
        check("boot_count", count_dbg, 1);
        check("boot_state", state_dbg, S_IDLE);
        drain;

        // Fill to DEPTH, fifth fetch blocked until one pop
        for (int i = 0; i < DEPTH; i++) begin
            issue(32'h100 + 32'(4 * i), 1'b0, 8'(i));
            respond(32'h1000_0100 + 32'(4 * i), 1'b1);
        end
        pc_valid = 1'b1; pc_in = 32'h110;
        #1;
        check("full_pc_ready", pc_ready, 0);
        check("full_mem_req", mem_req, 0);
        check("full_count", count_dbg, DEPTH);
        tick;
        inst_ready = 1'b1;
        #1;
        check("full_pc_ready_2", pc_ready, 0);
        tick;
        inst_ready = 1'b0;
        issue(32'h110, 1'b0, 8'h04);
        respond(32'h1000_0110, 1'b1);
        drain;

        // Simultaneous push and pop at count 2; metadata travels with its PC
        issue(32'h200, 1'b0, 8'h01); respond(32'hA000_0200, 1'b1);
        issue(32'h204, 1'b0, 8'h02); respond(32'hA000_0204, 1'b1);
        issue(32'h208, 1'b1, 8'h5A);
        mem_rvalid = 1'b1; mem_rdata = 32'hA000_0208; inst_ready = 1'b1;
        exp_q.push_back({32'hA000_0208, 32'h208, 1'b1, 8'h5A});
        #1;
        check("pp_count_before", count_dbg, 2);
        tick;
        mem_rvalid = 1'b0; inst_ready = 1'b0;
        #1;
        check("pp_count_after", count_dbg, 2);
        check("pp_head_pc", inst_pc_out, 32'h204);
        drain;

        // Flush while waiting: response arrives later in DISCARD and is dropped
        issue(32'h300, 1'b0, 8'h00); respond(32'hB000_0300, 1'b1);
        issue(32'h304, 1'b0, 8'h00);
        flush = 1'b1;
        #1;
        check("flush_pc_ready", pc_ready, 0);
        tick;
        exp_q.delete();
        #1;
        check("disc_state", state_dbg, S_DISC);
        check("disc_count", count_dbg, 0);
        check("disc_inst_valid", inst_valid, 0);
        tick;
        flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h400;
        #1;
        check("disc_flush_ignored", state_dbg, S_DISC);
        check("disc_mem_req", mem_req, 0);
        tick;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("disc_pc_ready", pc_ready, 0);
        tick;
        mem_rvalid = 1'b0;
        #1;
        check("disc_exit_state", state_dbg, S_IDLE);
        check("disc_dropped", count_dbg, 0);
        check("disc_then_ready", pc_ready, 1);
        issue(32'h400, 1'b0, 8'h33); respond(32'hC000_0400, 1'b1);
        drain;

        // Flush coincident with rvalid and pop at count 3
        for (int i = 0; i < 3; i++) begin
            issue(32'h500 + 32'(4 * i), 1'b0, 8'(i)); respond(32'hD000_0500 + 32'(i), 1'b1);
        end
        issue(32'h50C, 1'b1, 8'h77);
        mem_rvalid = 1'b1; mem_rdata = 32'hD000_050C; inst_ready = 1'b1; flush = 1'b1;
        tick;
        exp_q.delete();
        mem_rvalid = 1'b0; inst_ready = 1'b0; flush = 1'b0;
        #1;
        check("fc_count", count_dbg, 0);
        check("fc_inst_valid", inst_valid, 0);
        check("fc_state", state_dbg, S_IDLE);

        // Reset mid-fetch with 2 queued; late rvalid ignored
        issue(32'h600, 1'b0, 8'h01); respond(32'hE000_0600, 1'b1);
        issue(32'h604, 1'b1, 8'h02); respond(32'hE000_0604, 1'b1);
        issue(32'h608, 1'b0, 8'h03);
        rst = 1'b0;
        tick;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("mrst_state", state_dbg, S_IDLE);
        check("mrst_inst_valid", inst_valid, 0);
        check("mrst_inst_out", inst_out, 0);
        check("mrst_inst_pc", inst_pc_out, 0);
        check("mrst_pht", inst_pht_index_out, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0608;
        tick;
        mem_rvalid = 1'b0;
        #1;
        check("late_rvalid_count", count_dbg, 0);
        check("late_rvalid_valid", inst_valid, 0);

        // Random traffic with variable memory latency and back-pressure
        for (int n = 0; n < 12; n++) begin
            logic [AW-1:0] rpc;
            int k;
            rpc = 32'h8000_0000 + 32'($urandom_range(0, 1023) * 4);
            k = $urandom_range(1, 3);
            inst_ready = ($urandom_range(0, 1) == 1) && (count_dbg != 0);
            issue(rpc, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            mem_ready = 1'b1;
            for (int w = 1; w < k; w++) begin
                #1;
                check("rnd_wait_state", state_dbg, S_WAIT);
                tick;
            end
            respond(32'($urandom()), 1'b1);
            inst_ready = 1'b0;
            if (count_dbg == DEPTH) drain;
        end
        drain;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
